// File: rtl/fir_seq_pkg.sv
// rtl/fir_seq_pkg.sv - shared FSM encoding and default geometry for the FIR PE sequencer.
package fir_seq_pkg;

  localparam int unsigned NTAPS_DEF        = 8;
  localparam int unsigned IDX_W_DEF        = 3;
  localparam int unsigned MIN_WAIT_DEF     = 2;
  localparam int unsigned MULT_TIMEOUT_DEF = 31;
  localparam int unsigned CNT_W_DEF        = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROMRD,
    ST_START,
    ST_WAIT,
    ST_COMMIT
  } seq_state_e;

endpackage

// File: rtl/fir_seq_wait_timer.sv
// rtl/fir_seq_wait_timer.sv - multiplier wait counter with completion and timeout detection.
// The timeout path exists only when FIR_SEQ_TIMEOUT_EN is defined.
module fir_seq_wait_timer
  import fir_seq_pkg::*;
#(
  parameter int unsigned NTAPS        = NTAPS_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned MIN_WAIT     = MIN_WAIT_DEF,
  parameter int unsigned MULT_TIMEOUT = MULT_TIMEOUT_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [NTAPS-1:0] busy_i,
  output logic             done_o,
  output logic             timeout_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  // Decisions use the post-increment count, so it equals the number of wait cycles spent.
  // Saturating at the limit keeps an endless wait from wrapping back under MIN_WAIT.
  assign cnt_inc = (cnt_q == CNT_W'(MULT_TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = en_i && (cnt_inc >= CNT_W'(MIN_WAIT)) && (busy_i == '0);

`ifdef FIR_SEQ_TIMEOUT_EN
  assign timeout_o = en_i && !done_o && (cnt_inc == CNT_W'(MULT_TIMEOUT));
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: rtl/fir_pe_sequencer.sv
// rtl/fir_pe_sequencer.sv - busy-handshake control sequencer for the 8-PE systolic FIR datapath.
// FIR_SEQ_TIMEOUT_EN enables the forced-commit timeout and the sticky err_timeout flag.
module fir_pe_sequencer
  import fir_seq_pkg::*;
#(
  parameter int unsigned NTAPS        = NTAPS_DEF,
  parameter int unsigned IDX_W        = IDX_W_DEF,
  parameter int unsigned MIN_WAIT     = MIN_WAIT_DEF,
  parameter int unsigned MULT_TIMEOUT = MULT_TIMEOUT_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic             clk30x,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sample_load,
  input  logic [NTAPS-1:0] mult_busy,
  output logic             mult_start,
  output logic             commit,
  output logic [IDX_W-1:0] word_index,
  output logic [IDX_W-1:0] out_sel,
  output logic [NTAPS-1:0] clear_mask,
  output logic             rom_read_en,
  output logic             rom_ce,
  output logic             rom_tri_output,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_timeout,
  input  logic             clr_err
);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] word_index_q, word_index_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  logic             rom_en_q;
  logic             timer_clr, timer_en, wait_done, wait_timeout;

  fir_seq_wait_timer #(
    .NTAPS       (NTAPS),
    .CNT_W       (CNT_W),
    .MIN_WAIT    (MIN_WAIT),
    .MULT_TIMEOUT(MULT_TIMEOUT)
  ) u_wait_timer (
    .clk_i    (clk30x),
    .rst_ni   (rst),
    .clr_i    (timer_clr),
    .en_i     (timer_en),
    .busy_i   (mult_busy),
    .done_o   (wait_done),
    .timeout_o(wait_timeout)
  );

  always_comb begin
    state_d      = state_q;
    word_index_d = word_index_q;
    in_ready     = 1'b0;
    mult_start   = 1'b0;
    commit       = 1'b0;
    timer_clr    = 1'b0;
    timer_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = rom_en_q && (!out_valid_q || out_ready);
        if (in_valid && in_ready) state_d = ST_ROMRD;
      end
      ST_ROMRD: state_d = ST_START;
      ST_START: begin
        mult_start = 1'b1;
        timer_clr  = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        timer_en = 1'b1;
        if (wait_done || wait_timeout) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit       = 1'b1;
        word_index_d = word_index_q + IDX_W'(1);
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A commit in the same cycle as a downstream accept leaves a fresh word pending.
  assign out_valid_d = commit ? 1'b1 : ((out_valid_q && out_ready) ? 1'b0 : out_valid_q);
  assign err_d       = (err_q || wait_timeout) && !clr_err;

  always_ff @(posedge clk30x or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      word_index_q <= '0;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      rom_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_index_q <= word_index_d;
      out_valid_q  <= out_valid_d;
      err_q        <= err_d;
      rom_en_q     <= 1'b1;
    end
  end

  assign sample_load    = in_valid && in_ready;
  assign word_index     = word_index_q;
  assign out_sel        = word_index_q + IDX_W'(1);
  assign clear_mask     = NTAPS'(1) << word_index_q;
  assign rom_read_en    = rom_en_q;
  assign rom_ce         = rom_en_q;
  assign rom_tri_output = !rom_en_q;
  assign out_valid      = out_valid_q;
  assign err_timeout    = err_q;

endmodule

// File: tb/tb_fir_pe_sequencer.sv
// tb/tb_fir_pe_sequencer.sv - directed self-checking bench for fir_pe_sequencer.
module tb_fir_pe_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] mult_busy = 8'h00;
  logic       in_ready, sample_load, mult_start, commit;
  logic [2:0] word_index, out_sel;
  logic [7:0] clear_mask;
  logic       rom_read_en, rom_ce, rom_tri_output, out_valid, err_timeout;

  int n_cmp = 0;
  int n_fail = 0;
  int n_commit = 0;

  fir_pe_sequencer dut (
    .clk30x        (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .sample_load   (sample_load),
    .mult_busy     (mult_busy),
    .mult_start    (mult_start),
    .commit        (commit),
    .word_index    (word_index),
    .out_sel       (out_sel),
    .clear_mask    (clear_mask),
    .rom_read_en   (rom_read_en),
    .rom_ce        (rom_ce),
    .rom_tri_output(rom_tri_output),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .err_timeout   (err_timeout),
    .clr_err       (clr_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (commit === 1'b1) n_commit = n_commit + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One sample transfer; busy is high for busy_cyc WAIT cycles; lat is the cycle of commit (0 = none).
  task automatic do_sample(input int busy_cyc, input int bound, output int lat,
                           output logic [2:0] wi, output logic [2:0] os,
                           output logic ms2, output logic [7:0] cm);
    lat = 0; wi = 3'd0; os = 3'd0; ms2 = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; #1;
    cm = clear_mask;
    n_cmp++; if (sample_load !== 1'b1) begin $display("FAIL sample_load: got %b want 1", sample_load); n_fail++; end
    for (int c = 1; c <= bound; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      mult_busy = (c >= 3 && c < 3 + busy_cyc) ? 8'hFF : 8'h00;
      #1;
      if (c == 2) ms2 = mult_start;
      if (commit === 1'b1) begin lat = c; wi = word_index; os = out_sel; break; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk); #1;
    n_cmp++; if ({rom_read_en, rom_ce, rom_tri_output} !== 3'b001) begin $display("FAIL reset_rom: got %b want 001", {rom_read_en, rom_ce, rom_tri_output}); n_fail++; end
    n_cmp++; if ({in_ready, mult_start, commit, out_valid, err_timeout} !== 5'b0) begin $display("FAIL reset_outs: got %b want 00000", {in_ready, mult_start, commit, out_valid, err_timeout}); n_fail++; end
    n_cmp++; if (word_index !== 3'd0 || clear_mask !== 8'h01 || out_sel !== 3'd1) begin $display("FAIL reset_index: got wi=%0d cm=%h os=%0d want 0 01 1", word_index, clear_mask, out_sel); n_fail++; end
    rst = 1'b1; #1;
    n_cmp++; if (rom_ce !== 1'b0) begin $display("FAIL rom_before_edge: got %b want 0", rom_ce); n_fail++; end
    @(posedge clk); #1;
    n_cmp++; if ({rom_read_en, rom_ce, rom_tri_output} !== 3'b110) begin $display("FAIL rom_after_release: got %b want 110", {rom_read_en, rom_ce, rom_tri_output}); n_fail++; end
    n_cmp++; if ({in_ready, out_valid, err_timeout, commit} !== 4'b1000) begin $display("FAIL post_release: got %b want 1000", {in_ready, out_valid, err_timeout, commit}); n_fail++; end
  endtask

  task automatic test_single;
    int lat; logic [2:0] wi, os; logic ms2; logic [7:0] cm; int n0;
    out_ready = 1'b0;
    n0 = n_commit;
    do_sample(10, 40, lat, wi, os, ms2, cm);
    n_cmp++; if (lat !== 14) begin $display("FAIL single_latency: got %0d want 14", lat); n_fail++; end
    n_cmp++; if (ms2 !== 1'b1) begin $display("FAIL single_mult_start: got %b want 1", ms2); n_fail++; end
    n_cmp++; if (wi !== 3'd0 || os !== 3'd1) begin $display("FAIL single_commit_idx: got wi=%0d os=%0d want 0 1", wi, os); n_fail++; end
    @(posedge clk); #1;
    n_cmp++; if (word_index !== 3'd1 || out_valid !== 1'b1 || err_timeout !== 1'b0) begin $display("FAIL single_after: got wi=%0d ov=%b err=%b want 1 1 0", word_index, out_valid, err_timeout); n_fail++; end
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (n_commit - n0 !== 1) begin $display("FAIL single_commit_count: got %0d want 1", n_commit - n0); n_fail++; end
  endtask

  task automatic test_backpressure;
    int lat;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (in_ready !== 1'b0 || sample_load !== 1'b0) begin $display("FAIL bp_hold[%0d]: got rdy=%b ld=%b want 0 0", i, in_ready, sample_load); n_fail++; end
    end
    out_ready = 1'b1; #1;
    n_cmp++; if (sample_load !== 1'b1) begin $display("FAIL bp_release: got %b want 1", sample_load); n_fail++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin $display("FAIL bp_consumed: got %b want 0", out_valid); n_fail++; end
    lat = 0;
    for (int c = 2; c <= 20; c++) begin
      @(posedge clk); #1;
      if (commit === 1'b1) begin lat = c; break; end
    end
    n_cmp++; if (lat !== 5) begin $display("FAIL bp_latency: got %0d want 5", lat); n_fail++; end
    @(posedge clk); #1;
    n_cmp++; if (word_index !== 3'd2 || out_valid !== 1'b1) begin $display("FAIL bp_after: got wi=%0d ov=%b want 2 1", word_index, out_valid); n_fail++; end
  endtask

  task automatic test_reset_mid;
    int lat; logic [2:0] wi, os; logic ms2; logic [7:0] cm; int n0;
    do_sample(1000, 8, lat, wi, os, ms2, cm);
    n_cmp++; if (lat !== 0) begin $display("FAIL mid_no_early_commit: got %0d want 0", lat); n_fail++; end
    n0 = n_commit;
    rst = 1'b0; #1;
    n_cmp++; if ({commit, mult_start, out_valid, in_ready, rom_ce} !== 5'b0 || word_index !== 3'd0) begin $display("FAIL mid_reset: got %b wi=%0d want 00000 0", {commit, mult_start, out_valid, in_ready, rom_ce}, word_index); n_fail++; end
    repeat (2) @(posedge clk); #1;
    mult_busy = 8'h00;
    n_cmp++; if (n_commit !== n0) begin $display("FAIL mid_commit_count: got %0d want %0d", n_commit, n0); n_fail++; end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1 || word_index !== 3'd0) begin $display("FAIL mid_recover: got rdy=%b wi=%0d want 1 0", in_ready, word_index); n_fail++; end
  endtask

  task automatic test_back_to_back;
    int lat; logic [2:0] wi, os; logic ms2; logic [7:0] cm;
    logic [7:0] exp_mask [9];
    logic [2:0] exp_wi [9];
    logic [2:0] exp_os [9];
    exp_mask = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    exp_wi   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    exp_os   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      do_sample(0, 20, lat, wi, os, ms2, cm);
      n_cmp++; if (cm !== exp_mask[i]) begin $display("FAIL b2b_mask[%0d]: got %h want %h", i, cm, exp_mask[i]); n_fail++; end
      n_cmp++; if (wi !== exp_wi[i] || os !== exp_os[i]) begin $display("FAIL b2b_idx[%0d]: got wi=%0d os=%0d want %0d %0d", i, wi, os, exp_wi[i], exp_os[i]); n_fail++; end
      n_cmp++; if (lat !== 5) begin $display("FAIL b2b_latency[%0d]: got %0d want 5", i, lat); n_fail++; end
    end
    @(posedge clk); #1;
    n_cmp++; if (word_index !== 3'd1) begin $display("FAIL b2b_final_idx: got %0d want 1", word_index); n_fail++; end
  endtask

  task automatic test_timeout;
    int lat; logic [2:0] wi, os; logic ms2; logic [7:0] cm;
`ifdef FIR_SEQ_TIMEOUT_EN
    do_sample(1000, 50, lat, wi, os, ms2, cm);
    mult_busy = 8'h00;
    n_cmp++; if (lat !== 34) begin $display("FAIL timeout_latency: got %0d want 34", lat); n_fail++; end
    @(posedge clk); #1;
    n_cmp++; if (err_timeout !== 1'b1 || word_index !== 3'd2) begin $display("FAIL timeout_flag: got err=%b wi=%0d want 1 2", err_timeout, word_index); n_fail++; end
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    n_cmp++; if (err_timeout !== 1'b0) begin $display("FAIL timeout_clear: got %b want 0", err_timeout); n_fail++; end
`else
    do_sample(1000, 60, lat, wi, os, ms2, cm);
    n_cmp++; if (lat !== 0 || err_timeout !== 1'b0) begin $display("FAIL stuck_wait: got lat=%0d err=%b want 0 0", lat, err_timeout); n_fail++; end
    mult_busy = 8'h00;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (commit === 1'b1) begin lat = k; break; end
    end
    n_cmp++; if (lat !== 1) begin $display("FAIL stuck_release: got %0d want 1", lat); n_fail++; end
    @(posedge clk); #1;
    n_cmp++; if (word_index !== 3'd2 || err_timeout !== 1'b0) begin $display("FAIL stuck_after: got wi=%0d err=%b want 2 0", word_index, err_timeout); n_fail++; end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
